// File: rtl/tm_mul_sched.sv
// tm_mul_sched: two-requester round-robin front end feeding a truncated
// shift-and-add multiplier. Operand bits below index K are ignored, so the
// result is ((a>>K)*(b>>K))<<(2K) and takes 8-K cycles to compute.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a requester; ready is granted combinationally
// CALC  | one multiplier row of b per cycle, rows K..7
// DONE  | result held on out_prod/out_id until the consumer takes it
module tm_mul_sched #(
    parameter int K = 7,
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [W-1:0]      req0_a,
    input  logic [W-1:0]      req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [W-1:0]      req1_a,
    input  logic [W-1:0]      req1_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out_prod,
    output logic              out_id,
    output logic              busy
);

    localparam int RW = $clog2(W);
    localparam logic [W-1:0]  A_MASK    = W'({W{1'b1}} << K);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K);
    localparam logic [RW-1:0] ROW_LAST  = RW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic            prio;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [2*W-1:0]  acc;
    logic [RW-1:0]   row;
    logic            id_q;

    logic            grant_any;
    logic            grant_idx;
    logic [W-1:0]    grant_a;
    logic [W-1:0]    grant_b;
    logic [2*W-1:0]  partial;

    // Round-robin arbitration; ready is only offered in IDLE and never during reset.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
        if (state == IDLE && rst_n) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_idx = prio;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_idx = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester and the shifted partial product of the current row.
    always_comb begin
        grant_a = grant_idx ? req1_a : req0_a;
        grant_b = grant_idx ? req1_b : req0_b;
        partial = {{W{1'b0}}, a_q} << row;
    end

    assign req0_ready = grant_any && !grant_idx;
    assign req1_ready = grant_any &&  grant_idx;
    assign out_prod   = acc;
    assign out_id     = id_q;

    // Sequencer: latch on grant, accumulate one row per cycle, hold the result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            row       <= '0;
            id_q      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        // Low operand bits are cleared here so the row loop never sees them.
                        a_q   <= grant_a & A_MASK;
                        b_q   <= grant_b;
                        id_q  <= grant_idx;
                        prio  <= ~grant_idx;
                        acc   <= '0;
                        row   <= ROW_FIRST;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (b_q[row]) begin
                        acc <= acc + partial;
                    end
                    row <= row + 1'b1;
                    if (row == ROW_LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm_mul_sched.sv
// Bench for tm_mul_sched: three instances (K=7, K=4, K=0) exercised one at a
// time by a queue-based requester driver; a negedge monitor checks grants,
// busy, latency and results against a plain-arithmetic reference model.
module tb_tm_mul_sched;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } stim_t;

    typedef struct packed {
        logic [15:0] prod;
        logic        id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    int          cur = 0;
    int          kv = 7;

    logic        drv_v0 = 1'b0, drv_v1 = 1'b0, drv_ordy = 1'b1;
    logic [7:0]  drv_a0 = '0, drv_b0 = '0, drv_a1 = '0, drv_b1 = '0;

    logic [2:0]  r0, r1, ov, oid, bsy;
    logic [15:0] op [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KG = (g == 0) ? 7 : ((g == 1) ? 4 : 0);
        tm_mul_sched #(.K(KG)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0_valid (drv_v0 && (cur == g)),
            .req0_ready (r0[g]),
            .req0_a     (drv_a0),
            .req0_b     (drv_b0),
            .req1_valid (drv_v1 && (cur == g)),
            .req1_ready (r1[g]),
            .req1_a     (drv_a1),
            .req1_b     (drv_b1),
            .out_valid  (ov[g]),
            .out_ready  (drv_ordy && (cur == g)),
            .out_prod   (op[g]),
            .out_id     (oid[g]),
            .busy       (bsy[g])
        );
    end

    stim_t sq0[$];
    stim_t sq1[$];
    exp_t  q[$];

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    bit prio_m = 1'b0;
    int cyc = 0;
    bit taken0 = 1'b0, taken1 = 1'b0;
    bit pres0 = 1'b0, pres1 = 1'b0;
    int ordy_mode = 1;
    bit gaps = 1'b0;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input int k);
        int p;
        p = ((int'(a) >> k) * (int'(b) >> k)) << (2 * k);
        return p[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (K=%0d t=%0t): got %0h expected %0h", name, kv, $time, act, exp);
        end
    endtask

    task automatic push(input bit r, input logic [7:0] a, input logic [7:0] b);
        stim_t s;
        s.a = a;
        s.b = b;
        if (r) sq1.push_back(s);
        else   sq0.push_back(s);
    endtask

    // Monitor / scoreboard: grant prediction, busy, latency, and result compare.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit outst = (q.size() != 0);
            automatic bit e0 = 1'b0;
            automatic bit e1 = 1'b0;
            automatic int n = 8 - kv;
            automatic exp_t e;
            if (outst) cyc++;
            if (!outst) begin
                if (drv_v0 && drv_v1) begin
                    e0 = !prio_m;
                    e1 = prio_m;
                end else begin
                    e0 = drv_v0;
                    e1 = drv_v1;
                end
            end
            check("req0_ready", 32'(r0[cur]), 32'(e0));
            check("req1_ready", 32'(r1[cur]), 32'(e1));
            check("busy", 32'(bsy[cur]), 32'(outst));
            check("out_valid", 32'(ov[cur]), 32'(outst && (cyc > n)));
            if (outst && ov[cur]) begin
                check("out_prod", 32'(op[cur]), 32'(q[0].prod));
                check("out_id", 32'(oid[cur]), 32'(q[0].id));
                if (drv_ordy) void'(q.pop_front());
            end
            if (e0 || e1) begin
                e.id   = e1;
                e.prod = e1 ? model(drv_a1, drv_b1, kv) : model(drv_a0, drv_b0, kv);
                q.push_back(e);
                prio_m = !e1;
                cyc = 0;
                if (e1) taken1 = 1'b1;
                else    taken0 = 1'b1;
            end
        end
    end

    // Requester driver: present queued pairs, hold until accepted, scramble operands afterwards.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (taken0) begin
                void'(sq0.pop_front());
                taken0 = 1'b0;
                pres0 = 1'b0;
            end
            if (taken1) begin
                void'(sq1.pop_front());
                taken1 = 1'b0;
                pres1 = 1'b0;
            end
            if (!pres0 && sq0.size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) pres0 = 1'b1;
            if (!pres1 && sq1.size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) pres1 = 1'b1;
            drv_v0 = pres0;
            drv_v1 = pres1;
            if (pres0) begin
                drv_a0 = sq0[0].a;
                drv_b0 = sq0[0].b;
            end else begin
                drv_a0 = 8'($urandom);
                drv_b0 = 8'($urandom);
            end
            if (pres1) begin
                drv_a1 = sq1[0].a;
                drv_b1 = sq1[0].b;
            end else begin
                drv_a1 = 8'($urandom);
                drv_b1 = 8'($urandom);
            end
            case (ordy_mode)
                0:       drv_ordy = 1'b0;
                1:       drv_ordy = 1'b1;
                default: drv_ordy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (sq0.size() == 0 && sq1.size() == 0 && q.size() == 0 && !pres0 && !pres1) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout (K=%0d): pending stim0=%0d stim1=%0d results=%0d", kv, sq0.size(), sq1.size(), q.size());
        end
    endtask

    task automatic wait_out_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (ov[cur]) seen = 1'b1;
        end
        check("out_valid_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_accept();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (q.size() != 0) seen = 1'b1;
        end
        check("accept_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_inst(input int idx);
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        cur = idx;
        kv = (idx == 0) ? 7 : ((idx == 1) ? 4 : 0);
        rst_n = 1'b0;
        ordy_mode = 1;
        gaps = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(ov[cur]), 32'd0);
        check("rst_busy", 32'(bsy[cur]), 32'd0);
        check("rst_out_prod", 32'(op[cur]), 32'd0);
        check("rst_out_id", 32'(oid[cur]), 32'd0);
        @(posedge clk);
        #1;
        q.delete();
        prio_m = 1'b0;
        cyc = 0;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Directed operand cases, including the full-operand corner.
        if (idx == 0) begin
            push(1'b0, 8'h80, 8'h80);
            drain();
            push(1'b1, 8'h7F, 8'hFF);
            push(1'b1, 8'hFF, 8'hFF);
            drain();
        end else begin
            push(1'b0, 8'hFF, 8'hFF);
            drain();
        end

        // Both requesters continuously valid: grants must alternate.
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 8'($urandom), 8'($urandom));
            push(1'b1, 8'($urandom), 8'($urandom));
        end
        drain();

        // Consumer stalls in DONE while another request waits.
        ordy_mode = 0;
        push(1'b1, 8'($urandom), 8'($urandom));
        wait_out_valid();
        push(1'b0, 8'($urandom), 8'($urandom));
        repeat (6) @(posedge clk);
        #1;
        ordy_mode = 1;
        drain();

        // Random traffic with gaps and random back-pressure.
        gaps = 1'b1;
        ordy_mode = 2;
        for (int i = 0; i < 20; i++) push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        drain();
        gaps = 1'b0;
        ordy_mode = 1;

        // Reset during CALC: result discarded, prio cleared, pending req0 re-granted first.
        push(1'b0, 8'hFF, 8'hFF);
        push(1'b0, 8'($urandom), 8'($urandom));
        wait_accept();
        push(1'b1, 8'($urandom), 8'($urandom));
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_ready0_low", 32'(r0[cur]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", 32'(ov[cur]), 32'd0);
        check("abort_busy", 32'(bsy[cur]), 32'd0);
        check("abort_ready0", 32'(r0[cur]), 32'd0);
        check("abort_ready1", 32'(r1[cur]), 32'd0);
        @(posedge clk);
        #1;
        q.delete();
        prio_m = 1'b0;
        cyc = 0;
        taken0 = 1'b0;
        taken1 = 1'b0;
        rst_n = 1'b1;
        chk_en = 1'b1;
        drain();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) run_inst(i);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tm_mul_sched.md
TM_MUL_SCHED -- requirements
Module: tm_mul_sched

Interface
REQ-001 Parameter K, default 7: truncation level (legal 0..7); only operand bits at index >= K contribute.
REQ-002 Parameter W, fixed 8: operand width; product width 2*W = 16.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req0_valid  in  1  requester 0 has an operand pair.
REQ-007 req0_ready  out  1  requester 0 accepted this cycle.
REQ-008 req0_a, req0_b  in  8 each  requester 0 operands.
REQ-009 req1_valid  in  1  requester 1 has an operand pair.
REQ-010 req1_ready  out  1  requester 1 accepted this cycle.
REQ-011 req1_a, req1_b  in  8 each  requester 1 operands.
REQ-012 out_valid  out  1  result held on out_prod/out_id.
REQ-013 out_ready  in  1  consumer takes result.
REQ-014 out_prod  out  16  truncated product.
REQ-015 out_id  out  1  index of the requester that owns out_prod.
REQ-016 busy  out  1  high in CALC and DONE.

Function
REQ-017 Result SHALL equal ((a>>K)*(b>>K))<<(2K), 16-bit unsigned; this equals the sum of a[i]&b[j]<<(i+j) over i>=K, j>=K.
REQ-018 FSM states: IDLE, CALC, DONE; no other reachable state.
REQ-019 IDLE: req0_ready/req1_ready are combinational; at most one is high, and only when its valid is high.
REQ-020 Arbitration: round-robin pointer prio (reset 0); if only one valid, grant it; if both valid, grant prio.
REQ-021 On a grant, prio SHALL become the non-granted index; without a grant, prio is unchanged.
REQ-022 Grant edge: latch a with bits [K-1:0] cleared, latch b, latch id; acc <= 0; row <= K; IDLE->CALC.
REQ-023 CALC, each edge: if b[row], acc <= acc + (a_masked << row); row <= row + 1.
REQ-024 CALC lasts N = 8-K edges; on the edge processing row 7, go to DONE.
REQ-025 Latency: out_valid rises N cycles after the accept cycle (K=7 -> 1, K=0 -> 8).
REQ-026 DONE: out_valid=1; out_prod=acc and out_id stay stable until out_valid&out_ready.
REQ-027 DONE with out_ready=1: return to IDLE on that edge; no new grant in the same cycle.
REQ-028 Both ready outputs SHALL be 0 in CALC and DONE; requesters hold valid and operands until accepted.
REQ-029 The accumulator SHALL be 16-bit, and no overflow is possible.
REQ-030 Operand changes on req*_a/b after the accept edge SHALL NOT affect the result.

Reset
REQ-031 While rst_n=0 at an edge: state=IDLE, prio=0, acc=0, row=0, out_valid=0, out_prod=0, out_id=0, busy=0.
REQ-032 Reset asserted in CALC or DONE SHALL abort the operation and discard the result without emitting it.
REQ-033 Ready outputs SHALL be 0 while rst_n=0.

Verification
REQ-034 K=7, req0 a=0x80 b=0x80, out_ready=1 -> out_valid one cycle after accept, out_prod=0x4000, out_id=0.
REQ-035 K=7, req1 a=0x7F b=0xFF -> out_prod=0x0000, out_id=1; a=0xFF b=0xFF -> 0x4000.
REQ-036 K=4, a=0xFF b=0xFF -> out_prod=0xE100 after 4 cycles; K=0, same operands -> 0xFE01 after 8 cycles.
REQ-037 Both valid continuously after reset -> grants alternate 0,1,0,1 and out_id follows the same order.
REQ-038 out_ready=0 for 5 cycles in DONE -> out_prod/out_id held, no ready asserted; release -> IDLE, then next grant.
REQ-039 rst_n=0 mid-CALC -> next cycle out_valid=0, busy=0, prio=0, and the pending request is re-granted after release.
